// File: rtl/stack_row_judge_if.sv
// stack_row_judge_if
//   Bundles the slider/judge handshake of the block-stacker.
//   slave  : the judge itself (takes step/place/done_plot, drives the row state).
//   master : the surrounding logic (tick source, button, renderer, level FSM).
//   Signals: step_tick, place, done_plot (master -> slave);
//            slide_x, slide_w, base_x, base_w, row, next_signal, fail, win,
//            busy (slave -> master).
interface stack_row_judge_if #(
   parameter int XW = 4
);
   logic          step_tick;
   logic          place;
   logic          done_plot;
   logic [XW-1:0] slide_x;
   logic [XW-1:0] slide_w;
   logic [XW-1:0] base_x;
   logic [XW-1:0] base_w;
   logic [XW-1:0] row;
   logic          next_signal;
   logic          fail;
   logic          win;
   logic          busy;

   modport master (
      output step_tick, place, done_plot,
      input  slide_x, slide_w, base_x, base_w, row,
      input  next_signal, fail, win, busy
   );

   modport slave (
      input  step_tick, place, done_plot,
      output slide_x, slide_w, base_x, base_w, row,
      output next_signal, fail, win, busy
   );
endinterface

// File: rtl/stack_row_judge.sv
// stack_row_judge
//   Slides the active row across the board, judges a placement against the
//   stacked row below and reports next_signal / fail / win as one-cycle
//   pulses. busy holds the renderer handshake until done_plot arrives.
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset
//     bus   - stack_row_judge_if.slave (step/place/done_plot in, row state out)
module stack_row_judge #(
   parameter int COLS   = 16,
   parameter int XW     = 4,
   parameter int INIT_W = 3,
   parameter int ROWS   = 15
) (
   input  logic              clk,
   input  logic              reset,
   stack_row_judge_if.slave  bus
);

   typedef enum logic [1:0] {
      SLIDE,
      JUDGE,
      WAIT_DRAW
   } state_t;

   localparam logic [XW:0]   COLS_EXT = (XW+1)'(COLS);
   localparam logic [XW-1:0] LAST_ROW = XW'(ROWS - 1);
   localparam logic [XW-1:0] INIT_WX  = XW'(INIT_W);
   localparam logic [XW-1:0] ONE      = XW'(1);

   state_t        state_q;
   logic [XW-1:0] slide_x_q;
   logic [XW-1:0] slide_w_q;
   logic [XW-1:0] base_x_q;
   logic [XW-1:0] base_w_q;
   logic [XW-1:0] row_q;
   logic          dir_left_q;
   logic          restart_q;
   logic          next_q;
   logic          fail_q;
   logic          win_q;
   logic          busy_q;

   logic [XW:0]   slide_end;
   logic [XW:0]   base_end;
   logic [XW:0]   lo;
   logic [XW:0]   hi;
   logic [XW:0]   ov;

   // Overlap of the moving segment with the stacked span, one bit wider than
   // a column index so right edges at COLS do not wrap. Row 0 has nothing
   // below it, so the whole segment counts as overlap.
   always_comb begin
      slide_end = {1'b0, slide_x_q} + {1'b0, slide_w_q};
      base_end  = {1'b0, base_x_q} + {1'b0, base_w_q};
      lo        = '0;
      hi        = '0;
      ov        = '0;
      if (row_q == '0) begin
         lo = {1'b0, slide_x_q};
         hi = slide_end;
         ov = {1'b0, slide_w_q};
      end else begin
         lo = (slide_x_q > base_x_q) ? {1'b0, slide_x_q} : {1'b0, base_x_q};
         hi = (slide_end < base_end) ? slide_end : base_end;
         ov = (hi > lo) ? (hi - lo) : '0;
      end
   end

   // Main FSM. Result pulses default low every cycle so each lasts exactly
   // one clock. The restart flag remembers that the game ended (miss or win)
   // so the reload waits until the renderer has drawn the final row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SLIDE;
         slide_x_q  <= '0;
         slide_w_q  <= INIT_WX;
         base_x_q   <= '0;
         base_w_q   <= '0;
         row_q      <= '0;
         dir_left_q <= 1'b0;
         restart_q  <= 1'b0;
         next_q     <= 1'b0;
         fail_q     <= 1'b0;
         win_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         next_q <= 1'b0;
         fail_q <= 1'b0;
         win_q  <= 1'b0;
         case (state_q)
            SLIDE: begin
               // place wins over a simultaneous step so the judged position
               // is the one the player saw.
               if (bus.place) begin
                  state_q <= JUDGE;
               end else if (bus.step_tick) begin
                  if (!dir_left_q) begin
                     if (slide_end == COLS_EXT) begin
                        dir_left_q <= 1'b1;
                        slide_x_q  <= slide_x_q - ONE;
                     end else begin
                        slide_x_q <= slide_x_q + ONE;
                     end
                  end else begin
                     if (slide_x_q == '0) begin
                        dir_left_q <= 1'b0;
                        slide_x_q  <= slide_x_q + ONE;
                     end else begin
                        slide_x_q <= slide_x_q - ONE;
                     end
                  end
               end
            end

            JUDGE: begin
               state_q <= WAIT_DRAW;
               busy_q  <= 1'b1;
               if (ov == '0) begin
                  fail_q    <= 1'b1;
                  restart_q <= 1'b1;
               end else begin
                  // ov never exceeds slide_w, so it fits in XW bits.
                  base_x_q  <= lo[XW-1:0];
                  base_w_q  <= ov[XW-1:0];
                  slide_w_q <= ov[XW-1:0];
                  if (row_q == LAST_ROW) begin
                     win_q     <= 1'b1;
                     restart_q <= 1'b1;
                  end else begin
                     next_q     <= 1'b1;
                     row_q      <= row_q + ONE;
                     slide_x_q  <= '0;
                     dir_left_q <= 1'b0;
                  end
               end
            end

            WAIT_DRAW: begin
               if (bus.done_plot) begin
                  state_q <= SLIDE;
                  busy_q  <= 1'b0;
                  if (restart_q) begin
                     slide_x_q  <= '0;
                     slide_w_q  <= INIT_WX;
                     base_x_q   <= '0;
                     base_w_q   <= '0;
                     row_q      <= '0;
                     dir_left_q <= 1'b0;
                     restart_q  <= 1'b0;
                  end
               end
            end

            default: begin
               state_q <= SLIDE;
            end
         endcase
      end
   end

   assign bus.slide_x     = slide_x_q;
   assign bus.slide_w     = slide_w_q;
   assign bus.base_x      = base_x_q;
   assign bus.base_w      = base_w_q;
   assign bus.row         = row_q;
   assign bus.next_signal = next_q;
   assign bus.fail        = fail_q;
   assign bus.win         = win_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_stack_row_judge.sv
// tb_stack_row_judge
//   Self-checking bench for stack_row_judge. A column-counting reference
//   model predicts each judgement; predictions are queued when place is
//   driven and a negedge monitor pops them when a result pulse appears.
module tb_stack_row_judge;

   localparam int COLS   = 16;
   localparam int XW     = 4;
   localparam int INIT_W = 3;
   localparam int ROWS   = 15;

   localparam logic [2:0] K_NEXT = 3'b100;
   localparam logic [2:0] K_FAIL = 3'b010;
   localparam logic [2:0] K_WIN  = 3'b001;

   typedef struct {
      logic [2:0]    kind;
      logic [XW-1:0] bx;
      logic [XW-1:0] bw;
      logic [XW-1:0] sw;
      logic [XW-1:0] sx;
      logic [XW-1:0] row;
   } exp_t;

   logic clk;
   logic reset;

   stack_row_judge_if #(.XW(XW)) bus ();

   stack_row_judge #(
      .COLS   (COLS),
      .XW     (XW),
      .INIT_W (INIT_W),
      .ROWS   (ROWS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   compared   = 0;
   int   mismatched = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [2:0] mon_kind;

   // reference model state
   int m_x, m_w, m_bx, m_bw, m_row;
   bit m_left, m_restart;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result monitor: every pulse must match the oldest queued prediction.
   always @(negedge clk) begin
      if (!reset && (bus.next_signal || bus.fail || bus.win)) begin
         mon_kind = {bus.next_signal, bus.fail, bus.win};
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_pulse: saw kind=%b, required no pulse", mon_kind);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_kind !== mon_e.kind) begin
               mismatched++;
               $display("[TB] FAIL pulse_kind: saw %b, required %b", mon_kind, mon_e.kind);
            end
            compared++;
            if (bus.base_x !== mon_e.bx) begin
               mismatched++;
               $display("[TB] FAIL base_x: saw %0d, required %0d", bus.base_x, mon_e.bx);
            end
            compared++;
            if (bus.base_w !== mon_e.bw) begin
               mismatched++;
               $display("[TB] FAIL base_w: saw %0d, required %0d", bus.base_w, mon_e.bw);
            end
            compared++;
            if (bus.slide_w !== mon_e.sw) begin
               mismatched++;
               $display("[TB] FAIL slide_w: saw %0d, required %0d", bus.slide_w, mon_e.sw);
            end
            compared++;
            if (bus.slide_x !== mon_e.sx) begin
               mismatched++;
               $display("[TB] FAIL slide_x_after_judge: saw %0d, required %0d", bus.slide_x, mon_e.sx);
            end
            compared++;
            if (bus.row !== mon_e.row) begin
               mismatched++;
               $display("[TB] FAIL row_after_judge: saw %0d, required %0d", bus.row, mon_e.row);
            end
            compared++;
            if (bus.busy !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL busy_at_result: saw %b, required 1", bus.busy);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_x = 0; m_w = INIT_W; m_bx = 0; m_bw = 0; m_row = 0;
      m_left = 1'b0; m_restart = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step();
      if (!m_left) begin
         if (m_x + m_w == COLS) begin m_left = 1'b1; m_x--; end
         else m_x++;
      end else begin
         if (m_x == 0) begin m_left = 1'b0; m_x++; end
         else m_x--;
      end
   endtask

   // Judges by walking the columns rather than by interval arithmetic.
   task automatic model_place();
      exp_t e;
      int cnt, first;
      bit in_s, in_b;
      cnt = 0; first = -1;
      for (int c = 0; c < COLS; c++) begin
         in_s = (c >= m_x) && (c < m_x + m_w);
         in_b = (m_row == 0) || ((c >= m_bx) && (c < m_bx + m_bw));
         if (in_s && in_b) begin
            cnt++;
            if (first < 0) first = c;
         end
      end
      if (cnt == 0) begin
         e.kind = K_FAIL;
         m_restart = 1'b1;
      end else begin
         m_bx = first; m_bw = cnt; m_w = cnt;
         if (m_row == ROWS - 1) begin
            e.kind = K_WIN;
            m_restart = 1'b1;
         end else begin
            e.kind = K_NEXT;
            m_row++; m_x = 0; m_left = 1'b0;
         end
      end
      e.bx = XW'(m_bx); e.bw = XW'(m_bw); e.sw = XW'(m_w);
      e.sx = XW'(m_x); e.row = XW'(m_row);
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.step_tick = 1'b0; bus.place = 1'b0; bus.done_plot = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.step_tick = 1'b1;
         tick();
         bus.step_tick = 1'b0;
         model_step();
      end
   endtask

   task automatic place_now(input bit with_step);
      model_place();
      bus.place = 1'b1;
      bus.step_tick = with_step;
      tick();
      bus.place = 1'b0;
      bus.step_tick = 1'b0;
      for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL result_timeout: %0d predictions pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic draw_done();
      bus.done_plot = 1'b1;
      tick();
      bus.done_plot = 1'b0;
      if (m_restart) begin
         m_x = 0; m_w = INIT_W; m_bx = 0; m_bw = 0; m_row = 0;
         m_left = 1'b0; m_restart = 1'b0;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      compared++;
      if ({bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row} !== {4'd0, 4'd3, 4'd0, 4'd0, 4'd0}) begin
         mismatched++;
         $display("[TB] FAIL reset_fields: saw x=%0d w=%0d bx=%0d bw=%0d row=%0d, required 0 3 0 0 0",
                  bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row);
      end
      compared++;
      if ({bus.next_signal, bus.fail, bus.win, bus.busy} !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: saw %b, required 0000",
                  {bus.next_signal, bus.fail, bus.win, bus.busy});
      end
   endtask

   task automatic test_bounce();
      apply_reset();
      for (int i = 1; i <= 27; i++) begin
         step_n(1);
         compared++;
         if (bus.slide_x !== XW'(m_x)) begin
            mismatched++;
            $display("[TB] FAIL bounce_tick%0d: saw %0d, required %0d", i, bus.slide_x, m_x);
         end
      end
      // 14 ticks reach 12 moving left, 12 more reach 0, one more gives 1
      compared++;
      if (bus.slide_x !== 4'd1) begin
         mismatched++;
         $display("[TB] FAIL bounce_rebound: saw %0d, required 1", bus.slide_x);
      end
   endtask

   task automatic test_first_place();
      apply_reset();
      step_n(5);
      place_now(1'b0);
      // WAIT_DRAW ignores place and step
      for (int i = 0; i < 3; i++) begin
         bus.place = 1'b1; bus.step_tick = 1'b1;
         tick();
         bus.place = 1'b0; bus.step_tick = 1'b0;
         compared++;
         if ({bus.slide_x, bus.row, bus.busy} !== {4'd0, 4'd1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL wait_draw_hold: saw x=%0d row=%0d busy=%b, required 0 1 1",
                     bus.slide_x, bus.row, bus.busy);
         end
      end
      draw_done();
      compared++;
      if (bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL busy_release: saw %b, required 0", bus.busy);
      end
   endtask

   task automatic test_partial();
      step_n(6);
      place_now(1'b0);
      draw_done();
      compared++;
      if ({bus.base_x, bus.base_w, bus.slide_w, bus.row} !== {4'd6, 4'd2, 4'd2, 4'd2}) begin
         mismatched++;
         $display("[TB] FAIL partial_overlap: saw bx=%0d bw=%0d w=%0d row=%0d, required 6 2 2 2",
                  bus.base_x, bus.base_w, bus.slide_w, bus.row);
      end
   endtask

   task automatic test_miss();
      step_n(9);
      place_now(1'b0);
      draw_done();
      compared++;
      if ({bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row, bus.busy} !==
          {4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL miss_reload: saw x=%0d w=%0d bx=%0d bw=%0d row=%0d busy=%b, required 0 3 0 0 0 0",
                  bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row, bus.busy);
      end
   endtask

   task automatic test_collisions();
      step_n(3);
      bus.done_plot = 1'b1;
      tick();
      bus.done_plot = 1'b0;
      compared++;
      if ({bus.slide_x, bus.busy} !== {4'd3, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL done_plot_in_slide: saw x=%0d busy=%b, required 3 0", bus.slide_x, bus.busy);
      end
      step_n(1);
      place_now(1'b1);
      compared++;
      if (bus.base_x !== 4'd4) begin
         mismatched++;
         $display("[TB] FAIL place_step_collision: saw base_x=%0d, required 4", bus.base_x);
      end
      draw_done();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < ROWS; i++) begin
         place_now(1'b0);
         draw_done();
      end
      compared++;
      if ({bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row, bus.busy} !==
          {4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL win_reload: saw x=%0d w=%0d bx=%0d bw=%0d row=%0d busy=%b, required 0 3 0 0 0 0",
                  bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row, bus.busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      step_n(2);
      place_now(1'b0);
      #2;
      reset = 1'b1;
      #1;
      compared++;
      if ({bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row,
           bus.next_signal, bus.fail, bus.win, bus.busy} !==
          {4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'b0000}) begin
         mismatched++;
         $display("[TB] FAIL async_reset: saw x=%0d w=%0d bx=%0d bw=%0d row=%0d flags=%b, required 0 3 0 0 0 0000",
                  bus.slide_x, bus.slide_w, bus.base_x, bus.base_w, bus.row,
                  {bus.next_signal, bus.fail, bus.win, bus.busy});
      end
      tick();
      reset = 1'b0;
      model_reset();
      step_n(1);
      compared++;
      if (bus.slide_x !== 4'd1) begin
         mismatched++;
         $display("[TB] FAIL resume_after_reset: saw %0d, required 1", bus.slide_x);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.step_tick = 1'b0;
      bus.place = 1'b0;
      bus.done_plot = 1'b0;
      model_reset();
      test_reset();
      test_bounce();
      test_first_place();
      test_partial();
      test_miss();
      test_collisions();
      test_back_to_back();
      test_reset_mid_wait();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
